// File: rtl/mem_stage_if.sv
// EX/MEM-side inputs and MEM/WB-side outputs of the memory stage, bundled for port hookup.
// master drives the M-stage signals; slave is the mem_stage itself.
interface mem_stage_if;
  logic        regwriteM;
  logic        memwriteM;
  logic [1:0]  memtoregM;
  logic [1:0]  ext_sh_M;
  logic        ext_bh_M;
  logic [3:0]  BE_M;
  logic [31:0] ALU_outM;
  logic [31:0] WriteDataM;
  logic [31:0] PC_8M;
  logic [4:0]  WriteRegM;

  logic        regwriteW;
  logic [1:0]  memtoregW;
  logic [31:0] ALU_outW;
  logic [31:0] ReadDataW;
  logic [31:0] PC_8W;
  logic [4:0]  WriteRegW;

  modport master (
    output regwriteM, memwriteM, memtoregM, ext_sh_M, ext_bh_M, BE_M,
           ALU_outM, WriteDataM, PC_8M, WriteRegM,
    input  regwriteW, memtoregW, ALU_outW, ReadDataW, PC_8W, WriteRegW
  );

  modport slave (
    input  regwriteM, memwriteM, memtoregM, ext_sh_M, ext_bh_M, BE_M,
           ALU_outM, WriteDataM, PC_8M, WriteRegM,
    output regwriteW, memtoregW, ALU_outW, ReadDataW, PC_8W, WriteRegW
  );
endinterface

// File: rtl/mem_stage.sv
// Pipeline MEM stage: byte-enable data memory, load extraction/extension, MEM/WB register (1 cycle).
// Define DM_DISPLAY_EN to print every committed store in simulation.
module mem_stage #(
  parameter int DM_WORDS = 1024,
  parameter int ADDR_W   = 10
) (
  input  logic       clk,
  input  logic       reset,
  mem_stage_if.slave bus
);

  logic [31:0]       r_dmem [DM_WORDS];
  logic [ADDR_W-1:0] w_idx;
  logic [1:0]        w_off;
  logic [31:0]       w_rword;
  logic [31:0]       w_wdata;
  logic [31:0]       w_merged;
  logic [15:0]       w_half;
  logic [7:0]        w_byte;
  logic [31:0]       w_ext;

  assign w_idx   = bus.ALU_outM[ADDR_W+1:2];
  assign w_off   = bus.ALU_outM[1:0];
  assign w_rword = r_dmem[w_idx];

  // Sub-word stores arrive unshifted; replicate so every candidate lane holds the data.
  always_comb begin
    w_wdata = bus.WriteDataM;
    case (bus.BE_M)
      4'b0011, 4'b1100:                   w_wdata = {2{bus.WriteDataM[15:0]}};
      4'b0001, 4'b0010, 4'b0100, 4'b1000: w_wdata = {4{bus.WriteDataM[7:0]}};
      default:                            w_wdata = bus.WriteDataM;
    endcase
  end

  always_comb begin
    w_merged = w_rword;
    for (int i = 0; i < 4; i++) begin
      if (bus.BE_M[i]) w_merged[8*i +: 8] = w_wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DM_WORDS; i++) r_dmem[i] <= 32'd0;
    end else if (bus.memwriteM) begin
      r_dmem[w_idx] <= w_merged;
    end
  end

  assign w_half = w_off[1] ? w_rword[31:16] : w_rword[15:0];
  assign w_byte = w_rword[{w_off, 3'b000} +: 8];

  always_comb begin
    w_ext = w_rword;
    case (bus.ext_sh_M)
      2'b01:   w_ext = bus.ext_bh_M ? {{16{w_half[15]}}, w_half} : {16'd0, w_half};
      2'b10:   w_ext = bus.ext_bh_M ? {{24{w_byte[7]}}, w_byte} : {24'd0, w_byte};
      default: w_ext = w_rword;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.regwriteW <= 1'b0;
      bus.memtoregW <= 2'd0;
      bus.ALU_outW  <= 32'd0;
      bus.ReadDataW <= 32'd0;
      bus.PC_8W     <= 32'd0;
      bus.WriteRegW <= 5'd0;
    end else begin
      bus.regwriteW <= bus.regwriteM;
      bus.memtoregW <= bus.memtoregM;
      bus.ALU_outW  <= bus.ALU_outM;
      bus.ReadDataW <= w_ext;
      bus.PC_8W     <= bus.PC_8M;
      bus.WriteRegW <= bus.WriteRegM;
    end
  end

`ifdef DM_DISPLAY_EN
  always @(posedge clk) begin
    if (!reset && bus.memwriteM && bus.BE_M != 4'b0000)
      $display("@%h: *%h <= %h", bus.PC_8M - 32'd8, {bus.ALU_outM[31:2], 2'b00}, w_merged);
  end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected MEM/WB contents are queued when an op is driven
// and compared one cycle later.
module tb_mem_stage;
  logic clk = 1'b0;
  logic reset;

  mem_stage_if bus();

  mem_stage #(.DM_WORDS(1024), .ADDR_W(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rw;
    logic [1:0]  mtr;
    logic [31:0] alu;
    logic [31:0] rd;
    logic [31:0] pc;
    logic [4:0]  wr;
  } wexp_t;

  typedef struct {
    logic        mw;
    logic [3:0]  be;
    logic [1:0]  sh;
    logic        bh;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
  } row_t;

  wexp_t exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    seq   = 0;

  function automatic row_t R(logic mw, logic [3:0] be, logic [1:0] sh, logic bh,
                             logic [31:0] addr, logic [31:0] wd, logic [31:0] rd);
    row_t r;
    r.mw = mw; r.be = be; r.sh = sh; r.bh = bh; r.addr = addr; r.wd = wd; r.rd = rd;
    return r;
  endfunction

  function automatic wexp_t observed();
    return {bus.regwriteW, bus.memtoregW, bus.ALU_outW, bus.ReadDataW, bus.PC_8W, bus.WriteRegW};
  endfunction

  // Drives one op; the pass-through fields vary with a running sequence number.
  task automatic drive_row(input row_t r, output wexp_t e);
    logic [31:0] s;
    s = 32'(seq);
    seq++;
    bus.memwriteM  = r.mw;
    bus.BE_M       = r.be;
    bus.ext_sh_M   = r.sh;
    bus.ext_bh_M   = r.bh;
    bus.ALU_outM   = r.addr;
    bus.WriteDataM = r.wd;
    bus.regwriteM  = ~r.mw;
    bus.memtoregM  = s[1:0];
    bus.PC_8M      = 32'h0000_1000 + (s << 2);
    bus.WriteRegM  = s[4:0];
    e = {~r.mw, s[1:0], r.addr, r.rd, 32'h0000_1000 + (s << 2), s[4:0]};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    wexp_t e, g;
    drive_row(R(1'b1, 4'hF, 2'b00, 1'b0, 32'h0, 32'h1234_5678, 32'h0), e);
    exp_q.push_back(e);
    tick();
    g = observed(); e = exp_q.pop_front(); n_cmp++;
    if (g !== e) begin n_err++; $display("FAIL reset_pre_store: got %h want %h", g, e); end
    drive_row(R(1'b0, 4'h0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h1234_5678), e);
    exp_q.push_back(e);
    tick();
    g = observed(); e = exp_q.pop_front(); n_cmp++;
    if (g !== e) begin n_err++; $display("FAIL reset_pre_load: got %h want %h", g, e); end
    // Mid-cycle reset must clear outputs without a clock edge.
    #3;
    reset = 1'b1;
    exp_q.push_back('0);
    #1;
    g = observed(); e = exp_q.pop_front(); n_cmp++;
    if (g !== e) begin n_err++; $display("FAIL reset_async_outputs: got %h want %h", g, e); end
    #2;
    reset = 1'b0;
    drive_row(R(1'b0, 4'h0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0), e);
    exp_q.push_back(e);
    tick();
    g = observed(); e = exp_q.pop_front(); n_cmp++;
    if (g !== e) begin n_err++; $display("FAIL reset_mem_cleared: got %h want %h", g, e); end
  endtask

  task automatic test_word_bytes();
    row_t  rows[$];
    wexp_t e, g;
    rows.push_back(R(1'b1, 4'hF, 2'b00, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0));
    rows.push_back(R(1'b0, 4'h0, 2'b00, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF));
    rows.push_back(R(1'b1, 4'h8, 2'b00, 1'b0, 32'h13, 32'h0000_00A5, 32'hDEAD_BEEF));
    rows.push_back(R(1'b0, 4'h0, 2'b00, 1'b0, 32'h10, 32'h0, 32'hA5AD_BEEF));
    rows.push_back(R(1'b0, 4'h0, 2'b10, 1'b1, 32'h13, 32'h0, 32'hFFFF_FFA5));
    rows.push_back(R(1'b0, 4'h0, 2'b10, 1'b0, 32'h13, 32'h0, 32'h0000_00A5));
    rows.push_back(R(1'b0, 4'h0, 2'b10, 1'b1, 32'h10, 32'h0, 32'hFFFF_FFEF));
    rows.push_back(R(1'b0, 4'h0, 2'b10, 1'b0, 32'h11, 32'h0, 32'h0000_00BE));
    rows.push_back(R(1'b1, 4'h2, 2'b00, 1'b0, 32'h30, 32'h0000_00C3, 32'h0));
    rows.push_back(R(1'b0, 4'h0, 2'b00, 1'b0, 32'h30, 32'h0, 32'h0000_C300));
    foreach (rows[k]) begin
      drive_row(rows[k], e);
      exp_q.push_back(e);
      tick();
      g = observed(); e = exp_q.pop_front(); n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL word_bytes[%0d]: got %h want %h", k, g, e); end
    end
  endtask

  task automatic test_half_lanes();
    row_t  rows[$];
    wexp_t e, g;
    rows.push_back(R(1'b1, 4'hC, 2'b00, 1'b0, 32'h22, 32'h0000_8001, 32'h0));
    rows.push_back(R(1'b0, 4'h0, 2'b00, 1'b0, 32'h20, 32'h0, 32'h8001_0000));
    rows.push_back(R(1'b0, 4'h0, 2'b01, 1'b1, 32'h22, 32'h0, 32'hFFFF_8001));
    rows.push_back(R(1'b0, 4'h0, 2'b01, 1'b0, 32'h22, 32'h0, 32'h0000_8001));
    rows.push_back(R(1'b0, 4'h0, 2'b01, 1'b1, 32'h20, 32'h0, 32'h0000_0000));
    rows.push_back(R(1'b0, 4'h0, 2'b01, 1'b1, 32'h23, 32'h0, 32'hFFFF_8001));
    rows.push_back(R(1'b0, 4'h0, 2'b11, 1'b1, 32'h21, 32'h0, 32'h8001_0000));
    rows.push_back(R(1'b1, 4'h6, 2'b00, 1'b0, 32'h40, 32'h1122_3344, 32'h0));
    rows.push_back(R(1'b0, 4'h0, 2'b00, 1'b0, 32'h40, 32'h0, 32'h0022_3300));
    rows.push_back(R(1'b1, 4'h3, 2'b00, 1'b0, 32'h44, 32'hABCD_1234, 32'h0));
    rows.push_back(R(1'b0, 4'h0, 2'b00, 1'b0, 32'h44, 32'h0, 32'h0000_1234));
    foreach (rows[k]) begin
      drive_row(rows[k], e);
      exp_q.push_back(e);
      tick();
      g = observed(); e = exp_q.pop_front(); n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL half_lanes[%0d]: got %h want %h", k, g, e); end
    end
  endtask

  task automatic test_passthru_wrap();
    row_t  rows[$];
    wexp_t e, g;
    bus.regwriteM = 1'b1; bus.memwriteM = 1'b0; bus.memtoregM = 2'd2;
    bus.WriteRegM = 5'd31; bus.PC_8M = 32'h3008; bus.ALU_outM = 32'h1234;
    bus.BE_M = 4'h0; bus.ext_sh_M = 2'b00; bus.ext_bh_M = 1'b0; bus.WriteDataM = 32'h0;
    exp_q.push_back({1'b1, 2'd2, 32'h1234, 32'h0, 32'h3008, 5'd31});
    tick();
    g = observed(); e = exp_q.pop_front(); n_cmp++;
    if (g !== e) begin n_err++; $display("FAIL passthru: got %h want %h", g, e); end
    rows.push_back(R(1'b1, 4'hF, 2'b00, 1'b0, 32'h1010, 32'hCAFE_F00D, 32'hA5AD_BEEF));
    rows.push_back(R(1'b0, 4'h0, 2'b00, 1'b0, 32'h10, 32'h0, 32'hCAFE_F00D));
    rows.push_back(R(1'b0, 4'h0, 2'b00, 1'b0, 32'hFFFF_F010, 32'h0, 32'hCAFE_F00D));
    foreach (rows[k]) begin
      drive_row(rows[k], e);
      exp_q.push_back(e);
      tick();
      g = observed(); e = exp_q.pop_front(); n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL wrap[%0d]: got %h want %h", k, g, e); end
    end
  endtask

  task automatic test_zero_be_reset_race();
    row_t  rows[$];
    wexp_t e, g;
    rows.push_back(R(1'b1, 4'h0, 2'b00, 1'b0, 32'h10, 32'h0000_0000, 32'hCAFE_F00D));
    rows.push_back(R(1'b0, 4'h0, 2'b00, 1'b0, 32'h10, 32'h0, 32'hCAFE_F00D));
    foreach (rows[k]) begin
      drive_row(rows[k], e);
      exp_q.push_back(e);
      tick();
      g = observed(); e = exp_q.pop_front(); n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL zero_be[%0d]: got %h want %h", k, g, e); end
    end
    // Store is pending when reset rises just before the edge; it must be discarded.
    drive_row(R(1'b1, 4'hF, 2'b00, 1'b0, 32'h50, 32'hFFFF_FFFF, 32'h0), e);
    #8;
    reset = 1'b1;
    @(posedge clk);
    #4;
    reset = 1'b0;
    exp_q.push_back('0);
    g = observed(); e = exp_q.pop_front(); n_cmp++;
    if (g !== e) begin n_err++; $display("FAIL race_outputs: got %h want %h", g, e); end
    drive_row(R(1'b0, 4'h0, 2'b00, 1'b0, 32'h50, 32'h0, 32'h0), e);
    exp_q.push_back(e);
    tick();
    g = observed(); e = exp_q.pop_front(); n_cmp++;
    if (g !== e) begin n_err++; $display("FAIL race_word: got %h want %h", g, e); end
    drive_row(R(1'b0, 4'h0, 2'b00, 1'b0, 32'h10, 32'h0, 32'h0), e);
    exp_q.push_back(e);
    tick();
    g = observed(); e = exp_q.pop_front(); n_cmp++;
    if (g !== e) begin n_err++; $display("FAIL race_clears_all: got %h want %h", g, e); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, limit 100000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.regwriteM = 1'b0; bus.memwriteM = 1'b0; bus.memtoregM = 2'd0;
    bus.ext_sh_M = 2'd0; bus.ext_bh_M = 1'b0; bus.BE_M = 4'h0;
    bus.ALU_outM = 32'h0; bus.WriteDataM = 32'h0; bus.PC_8M = 32'h0; bus.WriteRegM = 5'd0;
    #12;
    reset = 1'b0;
    tick();
    test_reset();
    test_word_bytes();
    test_half_lanes();
    test_passthru_wrap();
    test_zero_be_reset_race();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
